// File: rtl/mips_processor.sv
// Single-cycle MIPS subset CPU: core (controller + datapath), instruction ROM and data RAM.
// Optional HI/LO multiply unit (mult, multu, mfhi, mflo) is built only when PROC_MULT_EN is defined.
package mips_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                         ALU_SLT = 3'd4, ALU_SLL = 3'd5, ALU_LUI = 3'd6;
  localparam logic [2:0] WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2, WB_HI = 3'd3, WB_LO = 3'd4;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
endpackage

module mips_controller import mips_pkg::*; (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       reg_write,
  output logic [1:0] dst_sel,
  output logic [2:0] wb_sel,
  output logic [2:0] alu_op,
  output logic       use_imm,
  output logic       zext,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       jump,
  output logic       jump_reg,
`ifdef PROC_MULT_EN
  output logic       mult_we,
  output logic       mult_signed,
`endif
  output logic       mem_write
);
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    reg_write = 1'b0; dst_sel = DST_RT; wb_sel = WB_ALU; alu_op = ALU_ADD;
    use_imm = 1'b0; zext = 1'b0; branch_eq = 1'b0; branch_ne = 1'b0;
    jump = 1'b0; jump_reg = 1'b0; mem_write = 1'b0;
`ifdef PROC_MULT_EN
    mult_we = 1'b0; mult_signed = 1'b0;
`endif
    case (op)
      6'h00: begin
        dst_sel = DST_RD;
        case (funct)
          6'h20, 6'h21: begin reg_write = 1'b1; alu_op = ALU_ADD; end
          6'h23:        begin reg_write = 1'b1; alu_op = ALU_SUB; end
          6'h24:        begin reg_write = 1'b1; alu_op = ALU_AND; end
          6'h25:        begin reg_write = 1'b1; alu_op = ALU_OR;  end
          6'h2A:        begin reg_write = 1'b1; alu_op = ALU_SLT; end
          6'h00:        begin reg_write = 1'b1; alu_op = ALU_SLL; end
          6'h08:        jump_reg = 1'b1;
`ifdef PROC_MULT_EN
          6'h18:        begin mult_we = 1'b1; mult_signed = 1'b1; end
          6'h19:        mult_we = 1'b1;
          6'h10:        begin reg_write = 1'b1; wb_sel = WB_HI; end
          6'h12:        begin reg_write = 1'b1; wb_sel = WB_LO; end
`endif
          default: ;
        endcase
      end
      6'h08, 6'h09: begin reg_write = 1'b1; use_imm = 1'b1; end
      6'h0A: begin reg_write = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
      6'h0C: begin reg_write = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_AND; end
      6'h0D: begin reg_write = 1'b1; use_imm = 1'b1; zext = 1'b1; alu_op = ALU_OR; end
      6'h0F: begin reg_write = 1'b1; alu_op = ALU_LUI; end
      6'h23: begin reg_write = 1'b1; use_imm = 1'b1; wb_sel = WB_MEM; end
      6'h2B: begin mem_write = 1'b1; use_imm = 1'b1; end
      6'h04: branch_eq = 1'b1;
      6'h05: branch_ne = 1'b1;
      6'h02: jump = 1'b1;
      6'h03: begin jump = 1'b1; reg_write = 1'b1; dst_sel = DST_RA; wb_sel = WB_PC4; end
      default: ;
    endcase
  end
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  // $0 has no storage; reads of it are forced to zero below.
  logic [31:0] registers [1:31];

  // NOTE: the array has no reset branch; only control state is reset, storage keeps its contents.
  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) registers[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : registers[ra2];
endmodule

module mips_datapath import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] instr,
  input  logic        reg_write,
  input  logic [1:0]  dst_sel,
  input  logic [2:0]  wb_sel,
  input  logic [2:0]  alu_op,
  input  logic        use_imm,
  input  logic        zext,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        jump_reg,
`ifdef PROC_MULT_EN
  input  logic        mult_we,
  input  logic        mult_signed,
`endif
  input  logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);
  logic [31:0] pc_q, pc_d, pc_plus4, rs_val, rt_val, imm_ext, alu_b, alu_y, wb_data;
  logic [4:0]  wa;

  mips_regfile gpr (
    .clk(clk), .we(reg_write && !reset), .ra1(instr[25:21]), .ra2(instr[20:16]),
    .wa(wa), .wd(wb_data), .rd1(rs_val), .rd2(rt_val)
  );

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign imm_ext   = zext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
  assign alu_b     = use_imm ? imm_ext : rt_val;
  assign mem_addr  = alu_y;
  assign mem_wdata = rt_val;
  assign mem_we    = mem_write && !reset;

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'h0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLL: alu_y = rt_val << instr[10:6];
      ALU_LUI: alu_y = {instr[15:0], 16'h0};
      default: alu_y = rs_val + alu_b;
    endcase
  end

  always_comb begin
    pc_d = pc_plus4;
    if (jump_reg)  pc_d = rs_val;
    else if (jump) pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if ((branch_eq && rs_val == rt_val) || (branch_ne && rs_val != rt_val))
      pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef PROC_MULT_EN
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic [63:0] op_a, op_b;

  // One 64x64 multiplier serves both forms; operands are sign- or zero-extended first.
  always_comb begin
    op_a = mult_signed ? {{32{rs_val[31]}}, rs_val} : {32'h0, rs_val};
    op_b = mult_signed ? {{32{rt_val[31]}}, rt_val} : {32'h0, rt_val};
    {hi_d, lo_d} = mult_we ? op_a * op_b : {hi_q, lo_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
`endif

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus4;
`ifdef PROC_MULT_EN
      WB_HI:   wb_data = hi_q;
      WB_LO:   wb_data = lo_q;
`endif
      default: wb_data = alu_y;
    endcase
    case (dst_sel)
      DST_RD:  wa = instr[15:11];
      DST_RA:  wa = 5'd31;
      default: wa = instr[20:16];
    endcase
  end
endmodule

module mips_core #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IAW      = 6,
  parameter int          DAW      = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    instr,
  input  logic [31:0]    mem_rdata,
  output logic [IAW-1:0] imem_idx,
  output logic [DAW-1:0] dmem_idx,
  output logic [31:0]    mem_wdata,
  output logic           mem_we
);
  logic        reg_write, use_imm, zext, branch_eq, branch_ne, jump, jump_reg, mem_write;
  logic [1:0]  dst_sel;
  logic [2:0]  wb_sel, alu_op;
  logic [31:0] pc, mem_addr;
`ifdef PROC_MULT_EN
  logic        mult_we, mult_signed;
`endif

  mips_controller ctrl (
    .op(instr[31:26]), .funct(instr[5:0]), .reg_write(reg_write), .dst_sel(dst_sel),
    .wb_sel(wb_sel), .alu_op(alu_op), .use_imm(use_imm), .zext(zext),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .jump_reg(jump_reg),
`ifdef PROC_MULT_EN
    .mult_we(mult_we), .mult_signed(mult_signed),
`endif
    .mem_write(mem_write)
  );

  mips_datapath #(.RESET_PC(RESET_PC)) dp (
    .clk(clk), .reset(reset), .instr(instr[25:0]), .reg_write(reg_write), .dst_sel(dst_sel),
    .wb_sel(wb_sel), .alu_op(alu_op), .use_imm(use_imm), .zext(zext),
    .branch_eq(branch_eq), .branch_ne(branch_ne), .jump(jump), .jump_reg(jump_reg),
`ifdef PROC_MULT_EN
    .mult_we(mult_we), .mult_signed(mult_signed),
`endif
    .mem_write(mem_write), .mem_rdata(mem_rdata), .pc(pc), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  // Word indices wrap modulo memory depth; byte-offset bits are ignored.
  assign imem_idx = pc[IAW+1:2];
  assign dmem_idx = mem_addr[DAW+1:2];
endmodule

module mips_imem #(parameter int WORDS = 64, parameter int AW = 6) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_idx,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] idx,
  output logic [31:0]   rdata
);
  logic [31:0] INSTRROM [WORDS];

  always_ff @(posedge clk) begin
    if (load_en) INSTRROM[load_idx] <= load_data;
  end

  assign rdata = INSTRROM[idx];
endmodule

module mips_dmem #(parameter int WORDS = 64, parameter int AW = 6) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] ram [WORDS];

  always_ff @(posedge clk) begin
    if (we) ram[idx] <= wdata;
  end

  assign rdata = ram[idx];
endmodule

module mips_processor #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic clk,
  input  logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [IAW-1:0] imem_idx;
  logic [DAW-1:0] dmem_idx;
  logic [31:0]    instr, mem_rdata, mem_wdata;
  logic           mem_we;

  mips_core #(.RESET_PC(RESET_PC), .IAW(IAW), .DAW(DAW)) mips (
    .clk(clk), .reset(reset), .instr(instr), .mem_rdata(mem_rdata), .imem_idx(imem_idx),
    .dmem_idx(dmem_idx), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  // The ROM load port is unused in the CPU; program images are placed directly into INSTRROM.
  mips_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) imem (
    .clk(clk), .load_en(1'b0), .load_idx('0), .load_data(32'h0), .idx(imem_idx), .rdata(instr)
  );

  mips_dmem #(.WORDS(DMEM_WORDS), .AW(DAW)) dmem (
    .clk(clk), .we(mem_we), .idx(dmem_idx), .wdata(mem_wdata), .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_mips_processor.sv
// Directed bench for mips_processor: loads small programs into the ROM, runs a fixed cycle
// count and compares GPR / PC contents against hand-computed values.
module tb_mips_processor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_regs [1:31];

  mips_processor dut (.clk(clk), .reset(reset));

  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gpr(input int i);
    return dut.mips.dp.gpr.registers[i];
  endfunction

  // Called at a falling edge: clear ROM to nops, zero the GPRs and hold reset.
  task automatic start_test();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.imem.INSTRROM[i] = 32'h0;
    for (int i = 1; i < 32; i++) dut.mips.dp.gpr.registers[i] = 32'h0;
    for (int i = 1; i < 32; i++) exp_regs[i] = 32'h0;
  endtask

  // One rising edge under reset, then n executed instructions.
  task automatic go(input int n);
    @(negedge clk);
    reset = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    for (int i = 1; i < 32; i++) check($sformatf("%s_r%0d", tag, i), gpr(i), exp_regs[i]);
  endtask

  initial begin
    // 1: constants
    start_test();
    dut.imem.INSTRROM[0] = 32'h3C011234;  // lui  $1,0x1234
    dut.imem.INSTRROM[1] = 32'h34215678;  // ori  $1,$1,0x5678
    @(negedge clk);
    check("reset_pc", dut.mips.dp.pc_q, 32'h0);
    reset = 1'b1;
    go(2);
    exp_regs[1] = 32'h12345678;
    check_all("const");

    // 2: Fibonacci loop, 29 cycles
    start_test();
    dut.imem.INSTRROM[0] = 32'h24020001;  // addiu $2,$0,1
    dut.imem.INSTRROM[1] = 32'h00221821;  // addu  $3,$1,$2
    dut.imem.INSTRROM[2] = 32'h00400821;  // addu  $1,$2,$0
    dut.imem.INSTRROM[3] = 32'h00601021;  // addu  $2,$3,$0
    dut.imem.INSTRROM[4] = 32'h24840001;  // addiu $4,$4,1
    dut.imem.INSTRROM[5] = 32'h1440FFFB;  // bne   $2,$0,-5
    go(29);
    exp_regs[1] = 32'd8;
    exp_regs[2] = 32'd13;
    exp_regs[3] = 32'd13;
    exp_regs[4] = 32'd5;
    check_all("fib");

    // 3: jal / jr
    start_test();
    dut.imem.INSTRROM[0] = 32'h0C000004;  // jal  word 4
    dut.imem.INSTRROM[1] = 32'h24050009;  // addiu $5,$0,9
    dut.imem.INSTRROM[4] = 32'h24020007;  // addiu $2,$0,7
    dut.imem.INSTRROM[5] = 32'h03E00008;  // jr   $31
    go(4);
    check("call_r31", gpr(31), 32'h00000004);
    check("call_r2", gpr(2), 32'd7);
    check("call_resume_r5", gpr(5), 32'd9);

    // 4: branches
    start_test();
    dut.imem.INSTRROM[0] = 32'h24010005;  // addiu $1,$0,5
    dut.imem.INSTRROM[1] = 32'h10200001;  // beq  $1,$0,+1 (not taken)
    dut.imem.INSTRROM[2] = 32'h14200001;  // bne  $1,$0,+1 (taken)
    dut.imem.INSTRROM[3] = 32'h24030001;  // addiu $3,$0,1 (skipped)
    dut.imem.INSTRROM[4] = 32'h24040002;  // addiu $4,$0,2
    go(4);
    check("br_r1", gpr(1), 32'd5);
    check("br_r3_skipped", gpr(3), 32'd0);
    check("br_r4_target", gpr(4), 32'd2);

    // 5: memory
    start_test();
    dut.imem.INSTRROM[0] = 32'h24010055;  // addiu $1,$0,0x55
    dut.imem.INSTRROM[1] = 32'hAC010008;  // sw   $1,8($0)
    dut.imem.INSTRROM[2] = 32'h8C020008;  // lw   $2,8($0)
    dut.imem.INSTRROM[3] = 32'h8C030009;  // lw   $3,9($0)
    go(4);
    check("mem_lw", gpr(2), 32'h55);
    check("mem_lw_unaligned", gpr(3), 32'h55);

    // 6: reset in cycle 3 discards the instruction there and restarts at word 0
    start_test();
    dut.imem.INSTRROM[0] = 32'h3C011234;  // lui  $1,0x1234
    dut.imem.INSTRROM[1] = 32'h34215678;  // ori  $1,$1,0x5678
    dut.imem.INSTRROM[2] = 32'h24010001;  // addiu $1,$0,1
    go(2);
    check("rst_pre_r1", gpr(1), 32'h12345678);
    reset = 1'b1;
    @(negedge clk);
    check("rst_discard_r1", gpr(1), 32'h12345678);
    check("rst_pc", dut.mips.dp.pc_q, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_lui_r1", gpr(1), 32'h12340000);
    @(negedge clk);
    check("rst_ori_r1", gpr(1), 32'h12345678);

    // 7: ALU corners, $0 write ignored, undefined opcode
    start_test();
    dut.mips.dp.gpr.registers[1] = 32'hFFFFFFFD;
    dut.mips.dp.gpr.registers[2] = 32'd5;
    dut.imem.INSTRROM[0] = 32'h24000005;  // addiu $0,$0,5
    dut.imem.INSTRROM[1] = 32'h24030003;  // addiu $3,$0,3
    dut.imem.INSTRROM[2] = 32'h0022202A;  // slt  $4,$1,$2
    dut.imem.INSTRROM[3] = 32'h00412823;  // subu $5,$2,$1
    dut.imem.INSTRROM[4] = 32'h00023100;  // sll  $6,$2,4
    dut.imem.INSTRROM[5] = 32'h28270000;  // slti $7,$1,0
    dut.imem.INSTRROM[6] = 32'hFC010001;  // undefined opcode
    dut.imem.INSTRROM[7] = 32'h3028FFF0;  // andi $8,$1,0xFFF0
    go(8);
    check("alu_r1_kept", gpr(1), 32'hFFFFFFFD);
    check("alu_r0_ignored", gpr(3), 32'd3);
    check("alu_slt", gpr(4), 32'd1);
    check("alu_subu", gpr(5), 32'd8);
    check("alu_sll", gpr(6), 32'h50);
    check("alu_slti", gpr(7), 32'd1);
    check("alu_andi_zext", gpr(8), 32'h0000FFF0);

    // 8: jump beyond ROM depth wraps the word index
    start_test();
    dut.imem.INSTRROM[0] = 32'h08000042;  // j    word 66
    dut.imem.INSTRROM[1] = 32'h24010001;  // addiu $1,$0,1 (skipped)
    dut.imem.INSTRROM[2] = 32'h24020002;  // addiu $2,$0,2
    go(1);
    check("wrap_pc", dut.mips.dp.pc_q, 32'h00000108);
    @(negedge clk);
    check("wrap_r1", gpr(1), 32'd0);
    check("wrap_r2", gpr(2), 32'd2);

`ifdef PROC_MULT_EN
    // 9: multu / mfhi / mflo
    start_test();
    dut.imem.INSTRROM[0] = 32'h3C010001;  // lui  $1,1
    dut.imem.INSTRROM[1] = 32'h00210019;  // multu $1,$1
    dut.imem.INSTRROM[2] = 32'h00001010;  // mfhi $2
    dut.imem.INSTRROM[3] = 32'h00001812;  // mflo $3
    go(4);
    check("mult_hi", gpr(2), 32'd1);
    check("mult_lo", gpr(3), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
